adder_seq_ctrl: RTL and testbench
=================================

# adder_seq_ctrl

Multi-precision add/subtract sequencer for the 16-bit adder datapath. Captures two WORDS×16-bit operands on a start pulse and drives one `Adder_16bit` instance word by word, least-significant word first, one word per clock. The inter-word carry is held in a register. The block presents the full-width result, carry/borrow out, and an optional signed-overflow flag with a one-cycle done pulse. It sits between the ALU control logic and the shared 16-bit adder slice, so wide operations reuse the existing adder hardware.

## Interface
- WORDS, 4, number of 16-bit words per operand; legal range 1..16; operand width W = 16*WORDS.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- start  input  1  request pulse; accepted only in IDLE.
- sub  input  1  0 = add, 1 = subtract (a - b); captured at accept.
- cin  input  1  carry-in for add; ignored when sub = 1; captured at accept.
- a  input  W  operand A; captured at accept.
- b  input  W  operand B; captured at accept.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when the result is valid.
- result  output  W  result register; holds its value until the next accepted start.
- cout  output  1  final carry out; for sub, 1 = no borrow.
- overflow  output  1  signed overflow of the W-bit operation (see Configuration).

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start = 1.
  - RUN→DONE when word index = WORDS-1.
  - DONE→IDLE unconditionally.
- Accept (IDLE and start = 1):
  - latch a, b, sub.
  - word index := 0.
  - carry register := (sub ? 1 : cin).
  - clear result, cout and overflow.
- RUN cycle with index i:
  - adder inputs are a[16i+15:16i], b[16i+15:16i] ^ {16{sub}}, and the carry register.
  - write the sum to result[16i+15:16i].
  - carry register := adder carry.
  - i := i+1.
- Last RUN word: cout := adder carry. Overflow is computed from the MSBs of A, of B' (B after the sub inversion) and of the sum: set when A_msb == B'_msb and sum_msb != A_msb.
- DONE: done = 1 for exactly one cycle. result, cout and overflow are stable from this cycle until the next accept.
- start outside IDLE (RUN or DONE) is ignored and not queued.
- Operand inputs may change freely after accept without affecting the operation.

## Timing
- Reset (rst_n = 0 at a rising edge):
  - state = IDLE, busy = 0, done = 0, result = 0, cout = 0, overflow = 0, carry register = 0.
  - Reset takes effect mid-RUN or in DONE and aborts the operation with no done pulse.
- Accept at edge T:
  - RUN occupies cycles T+1 … T+WORDS.
  - DONE (done = 1) is cycle T+WORDS+1.
  - IDLE at T+WORDS+2, where the earliest next accept occurs.
- Latency from start to done is WORDS+1 cycles. Throughput is one operation per WORDS+2 cycles.
- The carry between words is registered. The combinational path is one 16-bit adder plus the XOR inversion.
- WORDS = 1: RUN lasts one cycle; the behaviour is a registered 16-bit add.

## Configuration
- ADDSEQ_OVF_EN defined: overflow is computed as above and registered on the last RUN word.
- ADDSEQ_OVF_EN undefined: the overflow logic and MSB capture are not compiled, and overflow is tied to 0.
- All other behaviour and timing are identical in both builds.

## Test plan
- Add with carry ripple, WORDS = 4:
  - Stimulus: a = 0x0000_0000_FFFF_FFFF, b = 0x1, cin = 0, sub = 0, start at T.
  - Required: result = 0x0000_0001_0000_0000, cout = 0, overflow = 0, done high only at T+5, busy high T+1..T+5.
- Full-width carry:
  - Stimulus: a = b = 0xFFFF_FFFF_FFFF_FFFF, cin = 1.
  - Required: result = 0xFFFF_FFFF_FFFF_FFFF, cout = 1, overflow = 0.
- Subtract with borrow:
  - Stimulus: a = 0, b = 1, sub = 1, cin = 1 (cin ignored).
  - Required: result = 0xFFFF_FFFF_FFFF_FFFF, cout = 0, overflow = 0.
- Signed overflow:
  - Stimulus: a = 0x7FFF_FFFF_FFFF_FFFF, b = 1, add.
  - Required: result = 0x8000_0000_0000_0000, overflow = 1 with ADDSEQ_OVF_EN defined; overflow = 0 with it undefined.
- Start while busy:
  - Stimulus: second start with different operands at T+2 and at T+5 (DONE).
  - Required: both are ignored; the first result is unchanged; exactly one done pulse.
- Reset mid-run:
  - Stimulus: rst_n = 0 for one edge at T+2.
  - Required: next cycle has busy = 0, result = 0, no done pulse; a fresh start afterwards completes normally in 5 cycles.

Source files
------------

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: multi-precision add/subtract sequencer that reuses one 16-bit adder slice, LS word first.
// Optional feature macro ADDSEQ_OVF_EN builds the signed-overflow flag; without it overflow is tied to 0.

module Adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'b0, cin};
endmodule

module adder_seq_ctrl #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  sub,
    input  logic                  cin,
    input  logic [16*WORDS-1:0]   a,
    input  logic [16*WORDS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [16*WORDS-1:0]   result,
    output logic                  cout,
    output logic                  overflow
);
    localparam int W  = 16 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state_q;
    logic [IW-1:0]  idx_q;
    logic [IW-1:0]  idx_d;
    logic           carry_q;
    logic           sub_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   result_q;
    logic           cout_q;
    logic           busy_q;
    logic           done_q;

    logic [IW+3:0]  bitBase;
    logic [15:0]    opA;
    logic [15:0]    opB;
    logic [15:0]    sumWord;
    logic           carryOut;

    // Word i of each operand is selected by the index; subtraction inverts B and seeds carry with 1.
    assign bitBase = {idx_q, 4'b0000};
    assign opA     = a_q[bitBase +: 16];
    assign opB     = b_q[bitBase +: 16] ^ {16{sub_q}};
    assign idx_d   = idx_q + IW'(1);

    Adder_16bit uAdder (
        .a    (opA),
        .b    (opB),
        .cin  (carry_q),
        .sum  (sumWord),
        .cout (carryOut)
    );

`ifdef ADDSEQ_OVF_EN
    logic ovf_q;
    logic ovfWord;
    assign ovfWord  = (opA[15] == opB[15]) && (sumWord[15] != opA[15]);
    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef ADDSEQ_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= RUN;
                        a_q      <= a;
                        b_q      <= b;
                        sub_q    <= sub;
                        idx_q    <= '0;
                        carry_q  <= sub | cin;
                        result_q <= '0;
                        cout_q   <= 1'b0;
                        busy_q   <= 1'b1;
`ifdef ADDSEQ_OVF_EN
                        ovf_q    <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    result_q[bitBase +: 16] <= sumWord;
                    carry_q                 <= carryOut;
                    if (idx_q == LAST_IDX) begin
                        state_q <= DONE;
                        idx_q   <= '0;
                        cout_q  <= carryOut;
                        done_q  <= 1'b1;
`ifdef ADDSEQ_OVF_EN
                        ovf_q   <= ovfWord;
`endif
                    end else begin
                        idx_q <= idx_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: randomized and directed checks of adder_seq_ctrl against a whole-word arithmetic model.
// Honours ADDSEQ_OVF_EN the same way the design does.

module tb_adder_seq_ctrl;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          sub   = 1'b0;
    logic          cin   = 1'b0;
    logic [W-1:0]  a     = '0;
    logic [W-1:0]  b     = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          cout;
    logic          overflow;

    adder_seq_ctrl #(.WORDS(WORDS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .cin      (cin),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit checkEn     = 1'b0;

`ifdef ADDSEQ_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-word reference: plain W-bit add or subtract, signed overflow from operand/result signs.
    function automatic void computeExpected(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s, input logic c,
                                            output logic [W-1:0] r, output logic co, output logic ov);
        logic [W:0] full;
        if (s) begin
            r  = x - y;
            co = (x >= y);
            ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        end else begin
            full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
            r  = full[W-1:0];
            co = full[W];
            ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        end
        ov = ov & OVF_ON;
    endfunction

    int           mCnt    = 0;
    logic [W-1:0] mResult = '0;
    logic         mCout   = 1'b0;
    logic         mOvf    = 1'b0;
    logic [W-1:0] pRes    = '0;
    logic         pCout   = 1'b0;
    logic         pOvf    = 1'b0;
    logic [W:0]   mask    = '0;
    logic [W:0]   one     = 1;

    // mCnt: 0 idle, 1..WORDS running with mCnt-1 words written, WORDS+1 done.
    always @(posedge clk) begin
        if (!rst_n) begin
            mCnt = 0; mResult = '0; mCout = 1'b0; mOvf = 1'b0;
        end else if (mCnt == 0) begin
            if (start) begin
                computeExpected(a, b, sub, cin, pRes, pCout, pOvf);
                mResult = '0; mCout = 1'b0; mOvf = 1'b0;
                mCnt = 1;
            end
        end else if (mCnt <= WORDS) begin
            mCnt++;
            if (mCnt == WORDS + 1) begin
                mResult = pRes; mCout = pCout; mOvf = pOvf;
            end else begin
                mask    = (one << (16 * (mCnt - 1))) - one;
                mResult = pRes & mask[W-1:0];
            end
        end else begin
            mCnt = 0;
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("busy",     W'(busy),     W'(mCnt != 0));
            checkOutput("done",     W'(done),     W'(mCnt == WORDS + 1));
            checkOutput("result",   result,       mResult);
            checkOutput("cout",     W'(cout),     W'(mCout));
            checkOutput("overflow", W'(overflow), W'(mOvf));
        end
    end

    function automatic logic [W-1:0] randOperand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b0, {(W-1){1'b1}}};
            3:       return {1'b1, {(W-1){1'b0}}};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Pulses start for one edge, scrambles the operand inputs, then waits (bounded) for done.
    task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic s, input logic c, output int lat);
        a = x; b = y; sub = s; cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = randOperand(); b = randOperand(); sub = ~s; cin = ~c;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic runDirected(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic s, input logic c,
                               input logic [W-1:0] er, input logic ec, input logic eo);
        int lat;
        applyStimulus(x, y, s, c, lat);
        checkOutput({name, "Latency"}, W'(lat), W'(WORDS + 1));
        checkOutput({name, "Result"},  result, er);
        checkOutput({name, "Cout"},    W'(cout), W'(ec));
        checkOutput({name, "Ovf"},     W'(overflow), W'(eo));
        @(negedge clk);
    endtask

    initial begin
        int doneCount;
        int lat;
        repeat (2) @(negedge clk);
        checkEn = 1'b1;
        checkOutput("resetBusy",   W'(busy), '0);
        checkOutput("resetDone",   W'(done), '0);
        checkOutput("resetResult", result,   '0);
        rst_n = 1'b1;
        @(negedge clk);

        runDirected("ripple", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                    64'h0000_0001_0000_0000, 1'b0, 1'b0);
        runDirected("fullCarry", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        runDirected("borrow", 64'h0, 64'h1, 1'b1, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        runDirected("signedOvf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                    64'h8000_0000_0000_0000, 1'b0, OVF_ON);

        // Starts arriving in RUN (T+2) and DONE (T+5) must be dropped.
        a = 64'h0000_1234_0000_5678; b = 64'h0000_0001_0000_0002; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        doneCount = 0;
        for (int k = 1; k <= 8; k++) begin
            if (done) doneCount++;
            start = (k == 2 || k == 5);
            a = randOperand(); b = randOperand(); sub = $urandom; cin = $urandom;
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput("busyIgnoreDones",  W'(doneCount), W'(1));
        checkOutput("busyIgnoreResult", result, 64'h0000_1235_0000_567A);
        checkOutput("busyIgnoreIdle",   W'(busy), '0);

        // Reset during RUN aborts with no done pulse.
        a = 64'h1111_2222_3333_4444; b = 64'h1; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("abortBusy",   W'(busy), '0);
        checkOutput("abortDone",   W'(done), '0);
        checkOutput("abortResult", result,   '0);
        applyStimulus(64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0001, 1'b0, 1'b0, lat);
        checkOutput("freshLatency", W'(lat), W'(WORDS + 1));
        checkOutput("freshResult",  result,  64'h0000_0000_0000_0100);
        @(negedge clk);

        for (int n = 0; n < 1500; n++) begin
            start = ($urandom_range(0, 3) == 0);
            sub   = $urandom;
            cin   = $urandom;
            a     = randOperand();
            b     = randOperand();
            rst_n = ($urandom_range(0, 99) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (WORDS + 3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
